// File: rtl/soundbar_peak.sv
// Level-meter bar renderer with attack/decay smoothing; pixel_data is one cycle behind pixel_index.
// Peak-hold marker is built only when SOUNDBAR_PEAK_EN is defined; no backpressure, levels move on frame_tick.
module soundbar_peak #(
  parameter int WIDTH       = 96,
  parameter int HEIGHT      = 64,
  parameter int SEGMENTS    = 16,
  parameter int BORDER      = 3,
  parameter int BAR_X0      = 64,
  parameter int LOW_SEGS    = 5,
  parameter int MID_SEGS    = 10,
  parameter int HOLD_TICKS  = 30,
  parameter int DECAY_TICKS = 4,
  localparam int LW         = $clog2(SEGMENTS + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic [LW-1:0] level,
  input  logic [15:0]   col_bg,
  input  logic [15:0]   col_border,
  input  logic [15:0]   col_low,
  input  logic [15:0]   col_mid,
  input  logic [15:0]   col_high,
  input  logic [15:0]   col_peak,
  input  logic [12:0]   pixel_index,
  output logic [15:0]   pixel_data,
  output logic [LW-1:0] disp_level,
  output logic [LW-1:0] peak_level
);

  localparam int DW = $clog2(DECAY_TICKS + 1);
  localparam logic [LW-1:0] SEG_MAX  = LW'(SEGMENTS);
  localparam logic [DW-1:0] DEC_LAST = DW'(DECAY_TICKS - 1);

  localparam logic [12:0] W13      = 13'(WIDTH);
  localparam logic [12:0] NPIX     = 13'(WIDTH * HEIGHT);
  localparam logic [12:0] B13      = 13'(BORDER);
  localparam logic [12:0] XR       = 13'(WIDTH - BORDER);
  localparam logic [12:0] YB       = 13'(HEIGHT - BORDER);
  localparam logic [12:0] ROW_BASE = 13'(HEIGHT - BORDER - 1);
  localparam logic [12:0] X0       = 13'(BAR_X0);
  localparam logic [12:0] SEG13    = 13'(SEGMENTS);
  localparam logic [12:0] LOW13    = 13'(LOW_SEGS);
  localparam logic [12:0] MID13    = 13'(MID_SEGS);

  logic [LW-1:0] lsat;
  logic [LW-1:0] disp_nxt;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_nxt;
  logic          peak_hit;
  logic [15:0]   pix_nxt;
  logic [12:0]   px;
  logic [12:0]   py;
  logic [12:0]   dy;
  logic [12:0]   seg0;
  logic [1:0]    pit;

  assign lsat = (level > SEG_MAX) ? SEG_MAX : level;

  // Instant attack; otherwise step down one segment every DECAY_TICKS ticks, floored at the input.
  always_comb begin
    disp_nxt = disp_level;
    dcnt_nxt = dcnt;
    if (lsat > disp_level) begin
      disp_nxt = lsat;
      dcnt_nxt = '0;
    end else if (dcnt == DEC_LAST) begin
      dcnt_nxt = '0;
      if (disp_level > lsat) disp_nxt = disp_level - 1'b1;
    end else begin
      dcnt_nxt = dcnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_level <= '0;
      dcnt       <= '0;
    end else if (frame_tick) begin
      disp_level <= disp_nxt;
      dcnt       <= dcnt_nxt;
    end
  end

`ifdef SOUNDBAR_PEAK_EN
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_nxt;
  logic [LW-1:0] peak_nxt;

  // Floor against the post-tick display level so the marker never sinks into the bar.
  always_comb begin
    peak_nxt = peak_level;
    hcnt_nxt = hcnt;
    if (lsat >= peak_level) begin
      peak_nxt = lsat;
      hcnt_nxt = '0;
    end else if (hcnt != HOLD_MAX) begin
      hcnt_nxt = hcnt + 1'b1;
    end else if (peak_level > disp_nxt) begin
      peak_nxt = peak_level - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      peak_level <= '0;
      hcnt       <= '0;
    end else if (frame_tick) begin
      peak_level <= peak_nxt;
      hcnt       <= hcnt_nxt;
    end
  end

  assign peak_hit = (peak_level > disp_level) && ((seg0 + 13'd1) == 13'(peak_level));
`else
  logic unused_hold;
  assign unused_hold = (HOLD_TICKS > 0);
  assign peak_level  = '0;
  assign peak_hit    = 1'b0;
`endif

  // Segments count upward from the bottom row in a 3-row pitch: two lit rows, one gap row.
  always_comb begin
    py      = pixel_index / W13;
    px      = pixel_index - py * W13;
    dy      = ROW_BASE - py;
    seg0    = dy / 13'd3;
    pit     = 2'(dy - seg0 * 13'd3);
    pix_nxt = col_bg;
    if (pixel_index >= NPIX) begin
      pix_nxt = col_bg;
    end else if (px < B13 || px >= XR || py < B13 || py >= YB) begin
      pix_nxt = col_border;
    end else if (px >= X0 && pit != 2'd2 && seg0 < SEG13) begin
      if (seg0 < 13'(disp_level)) begin
        if (seg0 < LOW13)      pix_nxt = col_low;
        else if (seg0 < MID13) pix_nxt = col_mid;
        else                   pix_nxt = col_high;
      end else if (peak_hit) begin
        pix_nxt = col_peak;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pixel_data <= '0;
    else       pixel_data <= pix_nxt;
  end

endmodule

// File: tb/tb_soundbar_peak.sv
// Directed bench for soundbar_peak at default parameters; peak expectations follow SOUNDBAR_PEAK_EN.
module tb_soundbar_peak;
  localparam int LW = 5;
  localparam logic [15:0] C_BG   = 16'h0841;
  localparam logic [15:0] C_BRD  = 16'hFFFF;
  localparam logic [15:0] C_LOW  = 16'h07E0;
  localparam logic [15:0] C_MID  = 16'hFFE0;
  localparam logic [15:0] C_HIGH = 16'hF800;
  localparam logic [15:0] C_PEAK = 16'h001F;
`ifdef SOUNDBAR_PEAK_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          frame_tick;
  logic [LW-1:0] level;
  logic [12:0]   pixel_index;
  logic [15:0]   pixel_data;
  logic [LW-1:0] disp_level;
  logic [LW-1:0] peak_level;

  int asserts  = 0;
  int failures = 0;

  always #5 clock = ~clock;

  soundbar_peak dut (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .level      (level),
    .col_bg     (C_BG),
    .col_border (C_BRD),
    .col_low    (C_LOW),
    .col_mid    (C_MID),
    .col_high   (C_HIGH),
    .col_peak   (C_PEAK),
    .pixel_index(pixel_index),
    .pixel_data (pixel_data),
    .disp_level (disp_level),
    .peak_level (peak_level)
  );

  typedef struct {
    logic [LW-1:0] lvl;
    logic [12:0]   idx;
    logic [15:0]   exp;
    string         name;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input logic [LW-1:0] lv);
    @(negedge clock);
    level      = lv;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    level      = '0;
  endtask

  task automatic probe(input logic [12:0] idx);
    @(negedge clock);
    pixel_index = idx;
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] cur;
    int de, pe;
    reset       = 1'b1;
    frame_tick  = 1'b0;
    level       = '0;
    pixel_index = '0;
    #12;
    chk("reset_disp", 16'(disp_level), 16'd0);
    chk("reset_peak", 16'(peak_level), 16'd0);
    chk("reset_pix", pixel_data, 16'h0000);
    @(negedge clock);
    reset = 1'b0;

    // level without a tick must not move anything
    level = 5'd7;
    repeat (3) @(negedge clock);
    chk("no_tick_disp", 16'(disp_level), 16'd0);
    level = '0;

    // geometry and colour zones
    tbl.push_back('{5'd1,  13'd0,    C_BRD,  "geo_idx0"});
    tbl.push_back('{5'd1,  13'd5824, C_LOW,  "geo_seg1_lo"});
    tbl.push_back('{5'd1,  13'd5728, C_LOW,  "geo_seg1_hi"});
    tbl.push_back('{5'd1,  13'd5632, C_BG,   "geo_gap1"});
    tbl.push_back('{5'd1,  13'd5823, C_BG,   "geo_x63"});
    tbl.push_back('{5'd1,  13'd5852, C_LOW,  "geo_x92"});
    tbl.push_back('{5'd1,  13'd5853, C_BRD,  "geo_x93"});
    tbl.push_back('{5'd1,  13'd5536, C_BG,   "geo_5536"});
    tbl.push_back('{5'd1,  13'd5440, C_BG,   "geo_5440"});
    tbl.push_back('{5'd1,  13'd5535, C_BG,   "geo_5535"});
    tbl.push_back('{5'd1,  13'd6143, C_BRD,  "geo_last"});
    tbl.push_back('{5'd1,  13'd6144, C_BG,   "geo_oor"});
    tbl.push_back('{5'd1,  13'd8191, C_BG,   "geo_max"});
    tbl.push_back('{5'd16, 13'd4672, C_LOW,  "zone_seg5"});
    tbl.push_back('{5'd16, 13'd4576, C_LOW,  "zone_seg5_hi"});
    tbl.push_back('{5'd16, 13'd4384, C_MID,  "zone_seg6"});
    tbl.push_back('{5'd16, 13'd3232, C_MID,  "zone_seg10"});
    tbl.push_back('{5'd16, 13'd2944, C_HIGH, "zone_seg11"});
    tbl.push_back('{5'd16, 13'd1408, C_HIGH, "zone_seg16"});
    tbl.push_back('{5'd16, 13'd1312, C_BG,   "zone_gap16"});
    tbl.push_back('{5'd16, 13'd1216, C_BG,   "zone_above"});
    tbl.push_back('{5'd16, 13'd5536, C_LOW,  "zone_seg2"});
    cur = '0;
    foreach (tbl[i]) begin
      if (tbl[i].lvl != cur) begin
        tick(tbl[i].lvl);
        cur = tbl[i].lvl;
      end
      probe(tbl[i].idx);
      chk(tbl[i].name, pixel_data, tbl[i].exp);
    end
    chk("zone_disp", 16'(disp_level), 16'd16);

    // saturation
    pulse_reset();
    tick(5'd31);
    chk("sat_disp", 16'(disp_level), 16'd16);
    chk("sat_peak", 16'(peak_level), PK ? 16'd16 : 16'd0);

    // attack then decay
    pulse_reset();
    tick(5'd12);
    chk("atk_disp", 16'(disp_level), 16'd12);
    repeat (3) tick(5'd0);
    chk("dec_hold3", 16'(disp_level), 16'd12);
    tick(5'd0);
    chk("dec_4", 16'(disp_level), 16'd11);
    repeat (4) tick(5'd0);
    chk("dec_8", 16'(disp_level), 16'd10);

    // peak hold and release
    pulse_reset();
    tick(5'd10);
    chk("pk_attack", 16'(peak_level), PK ? 16'd10 : 16'd0);
    for (int t = 1; t <= 45; t++) begin
      tick(5'd0);
      de = (t / 4 >= 10) ? 0 : 10 - t / 4;
      pe = (t <= 30) ? 10 : 10 - (t - 30);
      if (pe < de) pe = de;
      chk($sformatf("pk_disp_t%0d", t), 16'(disp_level), 16'(de));
      chk($sformatf("pk_peak_t%0d", t), 16'(peak_level), PK ? 16'(pe) : 16'd0);
      if (t == 30) begin
        probe(13'd3232);
        chk("pk_marker", pixel_data, PK ? C_PEAK : C_BG);
        probe(13'd5248);
        chk("pk_seg3", pixel_data, C_LOW);
        probe(13'd4960);
        chk("pk_seg4", pixel_data, C_BG);
      end
    end

    // asynchronous reset mid-frame
    pulse_reset();
    tick(5'd9);
    probe(13'd5824);
    chk("ar_pre_pix", pixel_data, C_LOW);
    chk("ar_pre_disp", 16'(disp_level), 16'd9);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_disp", 16'(disp_level), 16'd0);
    chk("ar_peak", 16'(peak_level), 16'd0);
    chk("ar_pix", pixel_data, 16'h0000);
    frame_tick = 1'b1;
    level      = 5'd5;
    repeat (2) @(posedge clock);
    #1;
    chk("ar_tick_ignored", 16'(disp_level), 16'd0);
    @(negedge clock);
    frame_tick = 1'b0;
    reset      = 1'b0;
    tick(5'd3);
    chk("ar_post_disp", 16'(disp_level), 16'd3);
    chk("ar_post_peak", 16'(peak_level), PK ? 16'd3 : 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
